mem_arbiter: RTL and testbench

- Shares one unified, byte-addressed instruction/data memory between the multicycle MIPS fetch port and its load/store port.
- Sequences each access through a fixed number of wait states, drives the single memory port, and returns data plus a one-cycle ready pulse to the granted requester.
- Sits between the mips core and the unified memory (combinational read, synchronous write).

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/memarb_waitcnt.sv | 42 ++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and default constants for the unified
//                instruction/data memory arbiter.
//                Contents: arbiter state enum, grant enum, default widths
//                and wait-state count.
//  Options     : none (MEMARB_RR_EN is consumed by mem_arbiter)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int c_DW   = 32;   // data width
    localparam int c_AW   = 32;   // byte-address width
    localparam int c_WAIT = 1;    // extra memory wait cycles per access
    localparam int c_CW   = 4;    // wait counter width, 2**c_CW > c_WAIT

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_t;

endpackage

`default_nettype wire

// File: rtl/memarb_waitcnt.sv
// ============================================================================
//  Module      : memarb_waitcnt
//  Description : Loadable down-counter with a zero flag, used to sequence the
//                memory wait states of one arbitrated access.
//  Ports       : clk        - system clock
//                reset      - asynchronous active-low reset
//                i_load     - load i_load_val (has priority over i_dec)
//                i_load_val - value to load
//                i_dec      - decrement by one (saturates at zero)
//                o_zero     - count is zero
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module memarb_waitcnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one unified byte-addressed memory (combinational
//                read, synchronous write) between the MIPS fetch port (i_*)
//                and load/store port (d_*). Each access runs IDLE -> ACCESS
//                (WAIT+1 cycles) -> RESP; the granted port gets a one-cycle
//                ready pulse in RESP, with read data held in its rdata reg.
//  Ports       : clk, reset (async active-low)
//                i_req/i_adr -> i_ready/i_rdata           fetch port
//                d_req/d_we/d_adr/d_wdata -> d_ready/d_rdata  data port
//                m_adr/m_wd/m_we -> memory, m_rd <- memory
//  Options     : MEMARB_RR_EN  defined   : round-robin on simultaneous req
//                              undefined : data port has fixed priority
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW   = c_DW,
    parameter int AW   = c_AW,
    parameter int WAIT = c_WAIT,
    parameter int CW   = c_CW
) (
    input  logic          clk,
    input  logic          reset,
    // fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_adr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    // memory port
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_wd,
    output logic          m_we,
    input  logic [DW-1:0] m_rd
);

    localparam logic [CW-1:0] c_WAIT_LD = CW'(WAIT);

    arb_state_t    r_state;
    arb_gnt_t      r_gnt;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_wd;
    logic          r_we;
    logic          r_i_ready;
    logic          r_d_ready;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_any_req;
    logic          w_gnt_d;
    logic          w_cnt_load;
    logic          w_cnt_dec;
    logic          w_cnt_zero;

    assign w_any_req = i_req | d_req;

`ifdef MEMARB_RR_EN
    // Last-granted pointer; resets to fetch so the first tie goes to data.
    arb_gnt_t r_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= GNT_I;
        end else if ((r_state == IDLE) && w_any_req) begin
            r_last <= w_gnt_d ? GNT_D : GNT_I;
        end
    end

    assign w_gnt_d = d_req & (~i_req | (r_last == GNT_I));
`else
    assign w_gnt_d = d_req;
`endif

    assign w_cnt_load = (r_state == IDLE) && w_any_req;
    assign w_cnt_dec  = (r_state == ACCESS) && !w_cnt_zero;

    memarb_waitcnt #(
        .CW (CW)
    ) u_waitcnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (c_WAIT_LD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_gnt     <= GNT_I;
            r_adr     <= '0;
            r_wd      <= '0;
            r_we      <= 1'b0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt   <= w_gnt_d ? GNT_D : GNT_I;
                        r_adr   <= w_gnt_d ? d_adr : i_adr;
                        r_wd    <= w_gnt_d ? d_wdata : '0;
                        r_we    <= w_gnt_d & d_we;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Last wait cycle: the memory sees m_we / returns m_rd.
                    // Ready is raised here so it is visible during RESP.
                    if (w_cnt_zero) begin
                        if (!r_we) begin
                            if (r_gnt == GNT_D) begin
                                r_d_rdata <= m_rd;
                            end else begin
                                r_i_rdata <= m_rd;
                            end
                        end
                        if (r_gnt == GNT_D) begin
                            r_d_ready <= 1'b1;
                        end else begin
                            r_i_ready <= 1'b1;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Decoded from state so it falls the instant reset is asserted.
    assign m_we    = (r_state == ACCESS) && w_cnt_zero && r_we;
    assign m_adr   = r_adr;
    assign m_wd    = r_wd;
    assign i_ready = r_i_ready;
    assign d_ready = r_d_ready;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. Three DUTs
//                share one stimulus: g_dut[0] WAIT=1, g_dut[1] WAIT=3,
//                g_dut[2] WAIT=0, each with its own 64-word memory model.
//                Cycle 0 is the IDLE cycle in which a request is first seen.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_adr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;

    logic [2:0]  i_ready;
    logic [2:0]  d_ready;
    logic [2:0]  m_we;
    logic [31:0] i_rdata [3];
    logic [31:0] d_rdata [3];
    logic [31:0] m_adr   [3];
    logic [31:0] m_wd    [3];
    logic [31:0] m_rd    [3];

    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_dat;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        logic [31:0] mem [0:63];

        assign m_rd[g] = mem[m_adr[g][7:2]];

        always @(posedge clk) begin
            if (m_we[g]) mem[m_adr[g][7:2]] <= m_wd[g];
            else if (pl_we) mem[pl_idx] <= pl_dat;
        end

        mem_arbiter #(.DW(32), .AW(32), .WAIT(W), .CW(4)) u_dut (
            .clk     (clk),
            .reset   (reset),
            .i_req   (i_req),
            .i_adr   (i_adr),
            .i_ready (i_ready[g]),
            .i_rdata (i_rdata[g]),
            .d_req   (d_req),
            .d_we    (d_we),
            .d_adr   (d_adr),
            .d_wdata (d_wdata),
            .d_ready (d_ready[g]),
            .d_rdata (d_rdata[g]),
            .m_adr   (m_adr[g]),
            .m_wd    (m_wd[g]),
            .m_we    (m_we[g]),
            .m_rd    (m_rd[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        i_req = 1'b0; i_adr = '0; d_req = 1'b0; d_we = 1'b0;
        d_adr = '0; d_wdata = '0;
        reset = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
    endtask

    task automatic preload(input int idx, input logic [31:0] dat);
        pl_we = 1'b1; pl_idx = idx[5:0]; pl_dat = dat;
        tick;
        pl_we = 1'b0;
    endtask

    initial begin
        pl_we = 1'b0; pl_idx = '0; pl_dat = '0;
        do_reset;

        // Reset state of every instance
        for (int k = 0; k < 3; k++) begin
            chk("rst_i_ready", {31'd0, i_ready[k]}, 32'd0);
            chk("rst_d_ready", {31'd0, d_ready[k]}, 32'd0);
            chk("rst_i_rdata", i_rdata[k], 32'd0);
            chk("rst_d_rdata", d_rdata[k], 32'd0);
            chk("rst_m_adr",   m_adr[k],   32'd0);
            chk("rst_m_wd",    m_wd[k],    32'd0);
            chk("rst_m_we",    {31'd0, m_we[k]}, 32'd0);
        end

        // Fetch only, WAIT=1: ready in cycle 3
        preload(0, 32'h2002_0005);
        i_req = 1'b1; i_adr = 32'h0;
        for (int c = 0; c < 4; c++) begin
            chk("f_ready", {31'd0, i_ready[0]}, {31'd0, c == 3});
            chk("f_m_we",  {31'd0, m_we[0]}, 32'd0);
            if (c == 3) i_req = 1'b0;
            tick;
        end
        chk("f_ready_end", {31'd0, i_ready[0]}, 32'd0);
        chk("f_rdata", i_rdata[0], 32'h2002_0005);

        // Store 0x7 to 0x54: m_we only in cycle 2, ready in cycle 3
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h54; d_wdata = 32'h7;
        for (int c = 0; c < 4; c++) begin
            chk("st_m_we", {31'd0, m_we[0]}, {31'd0, c == 2});
            if (c == 2) begin
                chk("st_m_adr", m_adr[0], 32'h54);
                chk("st_m_wd",  m_wd[0],  32'h7);
            end
            chk("st_ready", {31'd0, d_ready[0]}, {31'd0, c == 3});
            if (c == 3) d_req = 1'b0;
            tick;
        end
        chk("st_m_we_end", {31'd0, m_we[0]}, 32'd0);
        chk("st_no_rdata", d_rdata[0], 32'd0);

        // Load back 0x54
        d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0;
        for (int c = 0; c < 4; c++) begin
            chk("ld_ready", {31'd0, d_ready[0]}, {31'd0, c == 3});
            chk("ld_m_we",  {31'd0, m_we[0]}, 32'd0);
            if (c == 3) d_req = 1'b0;
            tick;
        end
        chk("ld_rdata", d_rdata[0], 32'h7);

        // Simultaneous requests: data first (ready cycle 3), fetch re-arbitrated
        // in IDLE cycle 4, so its ready lands WAIT+2 later in cycle 7.
        do_reset;
        preload(2, 32'hCAFE_0008);
        i_req = 1'b1; i_adr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h54;
        for (int c = 0; c < 9; c++) begin
            chk("sim_d_ready", {31'd0, d_ready[0]}, {31'd0, c == 3});
            chk("sim_i_ready", {31'd0, i_ready[0]}, {31'd0, c == 7});
            if (c == 2) chk("sim_adr_d", m_adr[0], 32'h54);
            if (c == 6) chk("sim_adr_i", m_adr[0], 32'h8);
            if (c == 3) d_req = 1'b0;
            if (c == 7) i_req = 1'b0;
            tick;
        end
        chk("sim_d_rdata", d_rdata[0], 32'h7);
        chk("sim_i_rdata", i_rdata[0], 32'hCAFE_0008);

        // Both held for four accesses: responses in cycles 3,7,11,15
        do_reset;
        i_req = 1'b1; i_adr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h54;
        for (int c = 0; c < 16; c++) begin
            logic rdy;
            logic dwin;
            rdy  = (c % 4) == 3;
            dwin = 1'b1;
`ifdef MEMARB_RR_EN
            dwin = ((c / 4) % 2) == 0;
`endif
            chk("hold_d_ready", {31'd0, d_ready[0]}, {31'd0, rdy & dwin});
            chk("hold_i_ready", {31'd0, i_ready[0]}, {31'd0, rdy & ~dwin});
            tick;
        end
        i_req = 1'b0; d_req = 1'b0;

        // Reset mid-store, WAIT=3: write would be in cycle 4; reset in cycle 2
        do_reset;
        preload(24, 32'h1111_1111);
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h60; d_wdata = 32'hDEAD;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
                #1;
                chk("mr_m_adr_rst", m_adr[1], 32'h0);
            end
            if (c == 4) reset = 1'b1;
            chk("mr_m_we",   {31'd0, m_we[1]}, 32'd0);
            chk("mr_d_ready", {31'd0, d_ready[1]}, 32'd0);
            tick;
        end
        chk("mr_mem", g_dut[1].mem[24], 32'h1111_1111);
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h60;
        for (int c = 0; c < 7; c++) begin
            chk("mr_ld_ready", {31'd0, d_ready[1]}, {31'd0, c == 5});
            if (c == 5) d_req = 1'b0;
            tick;
        end
        chk("mr_ld_rdata", d_rdata[1], 32'h1111_1111);

        // WAIT=0 burst of four fetches: ready in cycles 2,5,8,11
        do_reset;
        for (int k = 0; k < 4; k++) preload(k, 32'h3000_0000 + k);
        i_req = 1'b1; i_adr = 32'h0;
        for (int c = 0; c < 14; c++) begin
            logic rdy;
            rdy = ((c % 3) == 2) && (c <= 11);
            chk("b_ready", {31'd0, i_ready[2]}, {31'd0, rdy});
            if (rdy) begin
                chk("b_rdata", i_rdata[2], 32'h3000_0000 + (c / 3));
                i_adr = ((c / 3) + 1) * 4;
                if (c == 11) i_req = 1'b0;
            end
            tick;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
